// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, keeps one icache request in flight, and
// presents one packet to IF/ID backed by a single skid entry; branch redirects flush.
module fetch_stage #(
  parameter int               XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = 32'h0000_1000
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            stall_i,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            icache_req_valid_o,
  input  logic            icache_req_ready_i,
  output logic [XLEN-1:0] icache_req_addr_o,
  input  logic            icache_rsp_valid_i,
  input  logic [31:0]     icache_rsp_data_i,
  output logic            if_valid_o,
  output logic [XLEN-1:0] if_pc_o,
  output logic [31:0]     if_instr_o
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_KILL
  } state_e;

  state_e          state_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] req_pc_q;
  logic            out_valid_q;
  logic [XLEN-1:0] out_pc_q;
  logic [31:0]     out_instr_q;
  logic            skid_valid_q;
  logic [XLEN-1:0] skid_pc_q;
  logic [31:0]     skid_instr_q;

  logic consume;
  logic req_fire;

  assign consume  = out_valid_q && !stall_i;
  assign req_fire = (state_q == S_REQ) && icache_req_ready_i;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      req_pc_q     <= '0;
      out_valid_q  <= 1'b0;
      out_pc_q     <= '0;
      out_instr_q  <= NOP;
      skid_valid_q <= 1'b0;
      skid_pc_q    <= '0;
      skid_instr_q <= NOP;
    end else if (redirect_valid_i) begin
      // A request already on its way (or firing now) must have its response dropped.
      pc_q         <= redirect_pc_i & ~XLEN'(3);
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      case (state_q)
        S_REQ:         state_q <= req_fire ? S_KILL : S_REQ;
        S_WAIT, S_KILL: state_q <= icache_rsp_valid_i ? S_REQ : S_KILL;
        default:       state_q <= S_REQ;
      endcase
    end else begin
      if (consume) begin
        out_valid_q <= 1'b0;
      end
      case (state_q)
        S_IDLE: state_q <= S_REQ;
        S_REQ: begin
          if (req_fire) begin
            req_pc_q <= pc_q;
            pc_q     <= pc_q + XLEN'(4);
            state_q  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (icache_rsp_valid_i) begin
            if (!out_valid_q || consume) begin
              out_valid_q <= 1'b1;
              out_pc_q    <= req_pc_q;
              out_instr_q <= icache_rsp_data_i;
              state_q     <= S_REQ;
            end else begin
              skid_valid_q <= 1'b1;
              skid_pc_q    <= req_pc_q;
              skid_instr_q <= icache_rsp_data_i;
              state_q      <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (consume) begin
            out_valid_q  <= skid_valid_q;
            out_pc_q     <= skid_pc_q;
            out_instr_q  <= skid_instr_q;
            skid_valid_q <= 1'b0;
            state_q      <= S_REQ;
          end
        end
        S_KILL: begin
          if (icache_rsp_valid_i) begin
            state_q <= S_REQ;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign icache_req_valid_o = (state_q == S_REQ);
  assign icache_req_addr_o  = pc_q;
  assign if_valid_o         = out_valid_q;
  assign if_pc_o            = out_pc_q;
  assign if_instr_o         = out_instr_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Randomised scoreboard bench for fetch_stage: a sequential-PC stream model predicts
// every fetch address and every delivered packet; a toy icache answers requests.
`timescale 1ns/1ps
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_1000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clock = 1'b0;
  logic        reset;
  logic        stall_i;
  logic        redirect_valid_i;
  logic [31:0] redirect_pc_i;
  logic        icache_req_valid_o;
  logic        icache_req_ready_i;
  logic [31:0] icache_req_addr_o;
  logic        icache_rsp_valid_i;
  logic [31:0] icache_rsp_data_i;
  logic        if_valid_o;
  logic [31:0] if_pc_o;
  logic [31:0] if_instr_o;

  fetch_stage #(.XLEN(32), .RESET_PC(RESET_PC)) dut (
    .clock              (clock),
    .reset              (reset),
    .stall_i            (stall_i),
    .redirect_valid_i   (redirect_valid_i),
    .redirect_pc_i      (redirect_pc_i),
    .icache_req_valid_o (icache_req_valid_o),
    .icache_req_ready_i (icache_req_ready_i),
    .icache_req_addr_o  (icache_req_addr_o),
    .icache_rsp_valid_i (icache_rsp_valid_i),
    .icache_rsp_data_i  (icache_rsp_data_i),
    .if_valid_o         (if_valid_o),
    .if_pc_o            (if_pc_o),
    .if_instr_o         (if_instr_o)
  );

  always #5 clock = ~clock;

  int vectors     = 0;
  int miscompares = 0;
  int pops        = 0;

  // Expected packet stream and next expected fetch address.
  logic [31:0] exp_pc_q[$];
  logic [31:0] exp_in_q[$];
  logic [31:0] model_pc;

  // Toy icache: one pending request with a response countdown.
  logic        pend = 1'b0;
  logic [31:0] pend_addr;
  int          pend_cnt;
  int          fixed_delay;

  logic        prev_hold, prev_req_wait;
  logic [31:0] prev_pc, prev_instr, prev_addr;
  int          idle_cycles;

  function automatic logic [31:0] imem(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_0F13;
  endfunction

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Monitor: sampled on the falling edge, mirrors what the DUT sees at the next rising edge.
  always @(negedge clock) begin
    if (!reset) begin
      prev_hold     = 1'b0;
      prev_req_wait = 1'b0;
      idle_cycles   = 0;
    end else begin
      if (prev_hold) begin
        chk("stall_hold_valid", {31'b0, if_valid_o}, 32'd1);
        chk("stall_hold_pc", if_pc_o, prev_pc);
        chk("stall_hold_instr", if_instr_o, prev_instr);
      end
      if (prev_req_wait) begin
        chk("req_hold_valid", {31'b0, icache_req_valid_o}, 32'd1);
        chk("req_hold_addr", icache_req_addr_o, prev_addr);
      end
      if (if_valid_o && !stall_i) begin
        pops++;
        idle_cycles = 0;
        if (exp_pc_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_packet: got pc %h with nothing expected", if_pc_o);
        end else begin
          chk("packet_pc", if_pc_o, exp_pc_q.pop_front());
          chk("packet_instr", if_instr_o, exp_in_q.pop_front());
        end
      end else if (!(if_valid_o && stall_i)) begin
        idle_cycles++;
        if (idle_cycles == 60) begin
          vectors++;
          miscompares++;
          $display("FAIL watchdog: got %0d idle cycles, required fewer than 60", idle_cycles);
        end
      end
      if (icache_req_valid_o && icache_req_ready_i) begin
        chk("req_addr", icache_req_addr_o, model_pc);
        chk("one_outstanding", {31'b0, pend}, 32'd0);
        if (!redirect_valid_i) begin
          exp_pc_q.push_back(model_pc);
          exp_in_q.push_back(imem(model_pc));
        end
        pend      = 1'b1;
        pend_addr = icache_req_addr_o;
        pend_cnt  = (fixed_delay > 0) ? fixed_delay : int'($urandom_range(1, 3));
        model_pc  = model_pc + 32'd4;
      end
      if (redirect_valid_i) begin
        exp_pc_q.delete();
        exp_in_q.delete();
        model_pc = {redirect_pc_i[31:2], 2'b00};
      end
      prev_hold     = if_valid_o && stall_i && !redirect_valid_i;
      prev_pc       = if_pc_o;
      prev_instr    = if_instr_o;
      prev_req_wait = icache_req_valid_o && !icache_req_ready_i && !redirect_valid_i;
      prev_addr     = icache_req_addr_o;
    end
  end

  task automatic drive(input logic st, input logic rd, input logic rv, input logic [31:0] ra);
    @(posedge clock);
    #1;
    stall_i            = st;
    icache_req_ready_i = rd;
    redirect_valid_i   = rv;
    redirect_pc_i      = ra;
    icache_rsp_valid_i = 1'b0;
    if (pend) begin
      pend_cnt--;
      if (pend_cnt <= 0) begin
        icache_rsp_valid_i = 1'b1;
        icache_rsp_data_i  = imem(pend_addr);
        pend               = 1'b0;
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_if_valid"}, {31'b0, if_valid_o}, 32'd0);
    chk({tag, "_if_pc"}, if_pc_o, 32'd0);
    chk({tag, "_if_instr"}, if_instr_o, NOP);
    chk({tag, "_req_valid"}, {31'b0, icache_req_valid_o}, 32'd0);
  endtask

  task automatic random_cycles(input int n);
    logic [31:0] tgt;
    for (int i = 0; i < n; i++) begin
      tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      drive($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 70,
            $urandom_range(0, 99) < 4, tgt);
    end
  endtask

  initial begin
    reset = 1'b0;
    stall_i = 1'b0; icache_req_ready_i = 1'b1;
    redirect_valid_i = 1'b0; redirect_pc_i = '0;
    icache_rsp_valid_i = 1'b0; icache_rsp_data_i = '0;
    fixed_delay = 1;
    model_pc = RESET_PC;
    repeat (3) @(posedge clock);
    #1 check_reset_outputs("reset");
    #2 reset = 1'b1;
    #1 chk("c0_req_valid", {31'b0, icache_req_valid_o}, 32'd0);

    drive(0, 1, 0, 0);  // c1
    chk("c1_req_valid", {31'b0, icache_req_valid_o}, 32'd1);
    chk("c1_req_addr", icache_req_addr_o, 32'h1000);
    drive(0, 1, 0, 0);  // c2: response
    drive(1, 1, 0, 0);  // c3
    chk("c3_if_valid", {31'b0, if_valid_o}, 32'd1);
    chk("c3_if_pc", if_pc_o, 32'h1000);
    chk("c3_req_addr", icache_req_addr_o, 32'h1004);
    drive(1, 1, 0, 0);  // c4: response goes to skid
    drive(1, 1, 0, 0);
    drive(1, 1, 0, 0);  // c6
    chk("c6_no_req", {31'b0, icache_req_valid_o}, 32'd0);
    chk("c6_if_pc", if_pc_o, 32'h1000);
    drive(1, 1, 0, 0);
    drive(0, 1, 0, 0);  // c8
    drive(0, 1, 0, 0);  // c9
    chk("c9_if_pc", if_pc_o, 32'h1004);
    chk("c9_req_addr", icache_req_addr_o, 32'h1008);
    chk("c9_req_valid", {31'b0, icache_req_valid_o}, 32'd1);
    fixed_delay = 2;
    drive(0, 1, 1, 32'h2002);  // c10: redirect while waiting
    drive(0, 1, 0, 0);         // c11: stale response dropped
    fixed_delay = 1;
    chk("c11_if_valid", {31'b0, if_valid_o}, 32'd0);
    chk("c11_no_req", {31'b0, icache_req_valid_o}, 32'd0);
    drive(0, 1, 0, 0);         // c12
    chk("c12_req_addr", icache_req_addr_o, 32'h2000);
    drive(0, 1, 0, 0);
    drive(0, 1, 0, 0);         // c14
    chk("c14_if_pc", if_pc_o, 32'h2000);
    chk("c14_if_instr", if_instr_o, imem(32'h2000));
    drive(0, 1, 1, 32'h2000);  // c15: redirect coincides with response
    drive(0, 0, 0, 0);         // c16
    chk("c16_if_valid", {31'b0, if_valid_o}, 32'd0);
    chk("c16_req_valid", {31'b0, icache_req_valid_o}, 32'd1);
    chk("c16_req_addr", icache_req_addr_o, 32'h2000);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);         // c19
    chk("c19_req_addr", icache_req_addr_o, 32'h2000);
    drive(0, 1, 0, 0);         // c20 fire
    drive(0, 1, 0, 0);
    drive(0, 1, 1, 32'hFFFF_FFFE);  // c22: redirect while firing
    chk("c22_if_pc", if_pc_o, 32'h2000);
    drive(0, 1, 0, 0);
    drive(0, 1, 0, 0);         // c24
    chk("c24_req_addr", icache_req_addr_o, 32'hFFFF_FFFC);
    drive(0, 1, 0, 0);
    drive(0, 1, 0, 0);         // c26
    chk("c26_wrap_addr", icache_req_addr_o, 32'h0000_0000);
    chk("c26_if_pc", if_pc_o, 32'hFFFF_FFFC);

    fixed_delay = 0;
    random_cycles(3000);

    @(posedge clock);
    #1 reset = 1'b0;
    #1 check_reset_outputs("midreset");
    stall_i = 1'b0; redirect_valid_i = 1'b0; icache_rsp_valid_i = 1'b0;
    pend = 1'b0;
    exp_pc_q.delete();
    exp_in_q.delete();
    model_pc = RESET_PC;
    @(posedge clock);
    #3 reset = 1'b1;
    random_cycles(1000);

    chk("progress", {31'b0, pops > 300}, 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
